ysyx_24100029_btb_ctrl: RTL and testbench

8-entry direct-mapped branch target buffer controller for the IF stage of the ysyx_24100029 core.
- Entry index is the 3-bit XOR-fold hash of the PC: hash[2] = XOR of pc bits ≡0 mod 3, hash[1] = XOR of bits ≡1 mod 3, hash[0] = XOR of bits ≡2 mod 3. Computed by the existing ysyx_24100029_hash instance.
- Serves a combinational lookup for fetch.
- Accepts resolved-branch updates from EXU via valid/ready.
- Runs a multi-cycle clear sequence on pipeline flush (fence.i / redirect-invalidate).

---
 rtl/ysyx_24100029_bpu_pkg.sv | 30 +++
 rtl/ysyx_24100029_hash.sv | 29 ++
 rtl/ysyx_24100029_btb_ctrl.sv | 129 ++++++++++++
 tb/tb_ysyx_24100029_btb_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100029_bpu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_bpu_pkg
// Shared definitions for the branch prediction unit of the ysyx_24100029 core:
// BTB geometry, the per-entry record, the BTB controller state encoding and
// the 2-bit direction counter values.
// ----------------------------------------------------------------------------
package ysyx_24100029_bpu_pkg;

   localparam int BTB_ENTRIES = 8;
   localparam int BTB_IDX_W   = 3;
   localparam int BTB_TAG_W   = 30;

   // 2-bit saturating direction counter values
   localparam logic [1:0] CNT_SNT = 2'd0;
   localparam logic [1:0] CNT_WT  = 2'd2;
   localparam logic [1:0] CNT_ST  = 2'd3;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           cnt;
   } btb_entry_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } btb_state_e;

endpackage : ysyx_24100029_bpu_pkg

// File: rtl/ysyx_24100029_hash.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_hash
// 3-bit XOR-fold of a 32-bit PC used as the BTB index.
//   hash[2] = XOR of pc bits whose position is 0 mod 3
//   hash[1] = XOR of pc bits whose position is 1 mod 3
//   hash[0] = XOR of pc bits whose position is 2 mod 3
// Ports:
//   pc   in  32  address to fold
//   hash out  3  BTB index
// ----------------------------------------------------------------------------
module ysyx_24100029_hash
   import ysyx_24100029_bpu_pkg::*;
(
   input  logic [31:0]          pc,
   output logic [BTB_IDX_W-1:0] hash
);

   always_comb begin
      hash = '0;
      for (int b = 0; b < 32; b++) begin
         case (b % 3)
            0:       hash[2] = hash[2] ^ pc[b];
            1:       hash[1] = hash[1] ^ pc[b];
            default: hash[0] = hash[0] ^ pc[b];
         endcase
      end
   end

endmodule : ysyx_24100029_hash

// File: rtl/ysyx_24100029_btb_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_btb_ctrl
// 8-entry direct-mapped branch target buffer controller for the IF stage.
// Combinational lookup for fetch, valid/ready update port from EXU, and an
// 8-cycle walking clear started by flush_req (fence.i / redirect-invalidate).
// Ports:
//   clock, reset               core clock, synchronous active-high reset
//   lk_pc                      fetch PC to look up
//   lk_hit/lk_taken/lk_target  lookup result (target is 0 on a miss)
//   upd_valid/upd_ready        resolved-branch handshake from EXU
//   upd_pc/upd_taken/upd_target resolved branch payload
//   flush_req                  one-cycle pulse: invalidate every entry
//   busy                       clear sequence in progress
// ----------------------------------------------------------------------------
module ysyx_24100029_btb_ctrl
   import ysyx_24100029_bpu_pkg::*;
#(
   parameter int         TAG_W    = BTB_TAG_W,
   parameter logic [1:0] INIT_CNT = CNT_WT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] lk_pc,
   output logic        lk_hit,
   output logic        lk_taken,
   output logic [31:0] lk_target,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        flush_req,
   output logic        busy
);

   function automatic logic [1:0] cnt_inc(input logic [1:0] c);
      return (c == CNT_ST) ? CNT_ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] cnt_dec(input logic [1:0] c);
      return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
   endfunction

   btb_state_e           state_q, state_d;
   logic [BTB_IDX_W-1:0] clr_idx_q, clr_idx_d;
   btb_entry_t           entries_q [BTB_ENTRIES];
   btb_entry_t           entries_d [BTB_ENTRIES];

   logic [BTB_IDX_W-1:0] lk_idx, upd_idx;
   btb_entry_t           lk_e, upd_e;
   logic                 upd_hit;

   ysyx_24100029_hash u_lk_hash  (.pc(lk_pc),  .hash(lk_idx));
   ysyx_24100029_hash u_upd_hash (.pc(upd_pc), .hash(upd_idx));

   assign busy      = (state_q == CLEAR);
   assign upd_ready = (state_q == IDLE) && !flush_req;

   // Lookup reads current register contents only; a same-cycle update is
   // not forwarded.
   assign lk_e      = entries_q[lk_idx];
   assign lk_hit    = !busy && lk_e.valid && (lk_e.tag == lk_pc[31:32-TAG_W]);
   assign lk_taken  = lk_hit && lk_e.cnt[1];
   assign lk_target = lk_hit ? lk_e.target : 32'd0;

   assign upd_e   = entries_q[upd_idx];
   assign upd_hit = upd_e.valid && (upd_e.tag == upd_pc[31:32-TAG_W]);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      entries_d = entries_q;
      unique case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
            end else if (upd_valid) begin
               if (upd_hit) begin
                  if (upd_taken) begin
                     entries_d[upd_idx].cnt    = cnt_inc(upd_e.cnt);
                     entries_d[upd_idx].target = upd_target;
                  end else begin
                     entries_d[upd_idx].cnt = cnt_dec(upd_e.cnt);
                  end
               end else if (upd_taken) begin
                  // Allocation simply overwrites whatever alias lived here.
                  entries_d[upd_idx].valid  = 1'b1;
                  entries_d[upd_idx].tag    = upd_pc[31:32-TAG_W];
                  entries_d[upd_idx].target = upd_target;
                  entries_d[upd_idx].cnt    = INIT_CNT;
               end
            end
         end
         CLEAR: begin
            entries_d[clr_idx_q].valid = 1'b0;
            if (flush_req) begin
               // A new flush restarts the walk so all 8 entries are cleared
               // after the most recent request.
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
               if (clr_idx_q == BTB_IDX_W'(BTB_ENTRIES - 1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Only control state and valid bits are reset; payload fields are
   // don't-care while their valid bit is low.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         clr_idx_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entries_q[i].valid  <= 1'b0;
            entries_q[i].tag    <= entries_d[i].tag;
            entries_q[i].target <= entries_d[i].target;
            entries_q[i].cnt    <= entries_d[i].cnt;
         end
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         for (int i = 0; i < BTB_ENTRIES; i++) entries_q[i] <= entries_d[i];
      end
   end

endmodule : ysyx_24100029_btb_ctrl

// File: tb/tb_ysyx_24100029_btb_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_24100029_btb_ctrl: a table of per-cycle vectors for the
// lookup/update behaviour, then hand-written sequences for flush, flush
// restart, flush/update collision and reset during the clear walk.
// ----------------------------------------------------------------------------
module tb_ysyx_24100029_btb_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] lk_pc;
   logic        lk_hit, lk_taken;
   logic [31:0] lk_target;
   logic        upd_valid, upd_ready;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush_req;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   ysyx_24100029_btb_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .lk_pc      (lk_pc),
      .lk_hit     (lk_hit),
      .lk_taken   (lk_taken),
      .lk_target  (lk_target),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .flush_req  (flush_req),
      .busy       (busy)
   );

   typedef struct {
      logic [31:0] lk;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utg;
      logic        e_hit;
      logic        e_tk;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg, input logic fl);
      @(negedge clock);
      lk_pc = lk; upd_valid = uv; upd_pc = upc; upd_taken = ut;
      upd_target = utg; flush_req = fl;
      #1;
   endtask

   function automatic vec_t mk(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utg,
                               input logic h, input logic t, input logic [31:0] g);
      vec_t v;
      v.lk = lk; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
      v.e_hit = h; v.e_tk = t; v.e_tgt = g;
      return v;
   endfunction

   localparam logic [31:0] PA = 32'h8000_0000; // index 2
   localparam logic [31:0] PB = 32'h8000_0004; // index 3
   localparam logic [31:0] PC = 32'h8000_0020; // index 3, aliases PB
   localparam logic [31:0] PD = 32'h8000_0005; // index 7
   localparam logic [31:0] PZ = 32'h0000_0000; // index 0, never allocated in table

   initial begin
      int cnt;
      // Expected values: counters start at 2 on allocation, saturate at 0/3,
      // lookups see the contents from before the current cycle's update.
      vecs[0]  = mk(PA, 0, 0,  0, 0,            0, 0, 0);
      vecs[1]  = mk(PA, 1, PA, 1, 32'h8000_0100, 0, 0, 0);              // commit, no bypass
      vecs[2]  = mk(PA, 0, 0,  0, 0,            1, 1, 32'h8000_0100); // cnt 2
      vecs[3]  = mk(PB, 1, PB, 1, 32'h8000_0040, 0, 0, 0);
      vecs[4]  = mk(PB, 1, PC, 1, 32'h8000_0080, 1, 1, 32'h8000_0040);
      vecs[5]  = mk(PB, 0, 0,  0, 0,            0, 0, 0);              // evicted alias
      vecs[6]  = mk(PC, 1, PC, 0, 32'h0,        1, 1, 32'h8000_0080); // cnt 2 -> 1
      vecs[7]  = mk(PC, 0, 0,  0, 0,            1, 0, 32'h8000_0080); // cnt 1
      vecs[8]  = mk(PA, 1, PA, 1, 32'h8000_0100, 1, 1, 32'h8000_0100); // pre 2
      vecs[9]  = mk(PA, 1, PA, 1, 32'h8000_0100, 1, 1, 32'h8000_0100); // pre 3
      vecs[10] = mk(PA, 1, PA, 1, 32'h8000_0100, 1, 1, 32'h8000_0100); // pre 3
      vecs[11] = mk(PA, 1, PA, 0, 32'h0,        1, 1, 32'h8000_0100); // pre 3
      vecs[12] = mk(PA, 1, PA, 0, 32'h0,        1, 1, 32'h8000_0100); // pre 2
      vecs[13] = mk(PA, 1, PA, 0, 32'h0,        1, 0, 32'h8000_0100); // pre 1
      vecs[14] = mk(PA, 1, PA, 0, 32'h0,        1, 0, 32'h8000_0100); // pre 0
      vecs[15] = mk(PA, 1, PA, 0, 32'h0,        1, 0, 32'h8000_0100); // pre 0 (5th NT)
      vecs[16] = mk(PA, 1, PA, 1, 32'h8000_0100, 1, 0, 32'h8000_0100); // pre 0
      vecs[17] = mk(PA, 0, 0,  0, 0,            1, 0, 32'h8000_0100); // cnt 1
      vecs[18] = mk(PZ, 1, PZ, 0, 32'h1234_0000, 0, 0, 0);
      vecs[19] = mk(PZ, 0, 0,  0, 0,            0, 0, 0);              // NT miss allocated nothing

      reset = 1'b1; lk_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
      upd_target = 0; flush_req = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].lk, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg, 1'b0);
         chk($sformatf("v%0d.lk_hit", i),    32'(lk_hit),    32'(vecs[i].e_hit));
         chk($sformatf("v%0d.lk_taken", i),  32'(lk_taken),  32'(vecs[i].e_tk));
         chk($sformatf("v%0d.lk_target", i), lk_target,      vecs[i].e_tgt);
         chk($sformatf("v%0d.busy", i),      32'(busy),      32'd0);
         chk($sformatf("v%0d.upd_ready", i), 32'(upd_ready), 32'd1);
      end

      // ---- Flush: entries at 2 and 3 valid; update held during the walk ----
      drive(PA, 0, 0, 0, 0, 1'b1);
      chk("flush_pulse.ready", 32'(upd_ready), 32'd0);
      chk("flush_pulse.hit",   32'(lk_hit),    32'd1);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         drive(PC, 1, PA, 1, 32'h8000_0200, 1'b0);
         if (!busy) break;
         cnt++;
         chk($sformatf("flush_c%0d.hit", cnt),   32'(lk_hit),    32'd0);
         chk($sformatf("flush_c%0d.ready", cnt), 32'(upd_ready), 32'd0);
      end
      chk("flush.busy_cycles", 32'(cnt), 32'd8);
      chk("flush.idle_ready", 32'(upd_ready), 32'd1);
      chk("flush.idx3_cleared", 32'(lk_hit), 32'd0);
      drive(PA, 0, 0, 0, 0, 1'b0);
      chk("flush.post_upd_hit",    32'(lk_hit),    32'd1);
      chk("flush.post_upd_taken",  32'(lk_taken),  32'd1);
      chk("flush.post_upd_target", lk_target,      32'h8000_0200);

      // ---- Flush restarted at clear cycle 5 ----
      drive(PA, 0, 0, 0, 0, 1'b1);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         drive(PA, 0, 0, 0, 0, (cnt == 4) ? 1'b1 : 1'b0);
         if (!busy) break;
         cnt++;
         chk($sformatf("restart_c%0d.hit", cnt), 32'(lk_hit), 32'd0);
      end
      chk("restart.busy_cycles", 32'(cnt), 32'd13);

      // ---- Simultaneous flush and update in IDLE ----
      drive(PB, 1, PB, 1, 32'h8000_0444, 1'b1);
      chk("collide.ready", 32'(upd_ready), 32'd0);
      chk("collide.busy",  32'(busy),      32'd0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         drive(PB, 0, 0, 0, 0, 1'b0);
         if (!busy) break;
         cnt++;
      end
      chk("collide.busy_cycles", 32'(cnt), 32'd8);
      chk("collide.no_alloc",    32'(lk_hit), 32'd0);

      // ---- Reset in the middle of CLEAR ----
      drive(PD, 1, PD, 1, 32'h8000_0700, 1'b0);
      drive(PD, 0, 0, 0, 0, 1'b0);
      chk("rst_mid.pre_hit", 32'(lk_hit), 32'd1);
      drive(PD, 0, 0, 0, 0, 1'b1);
      drive(PD, 0, 0, 0, 0, 1'b0);
      drive(PD, 0, 0, 0, 0, 1'b0);
      chk("rst_mid.busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      drive(PD, 0, 0, 0, 0, 1'b0);
      reset = 1'b0;
      drive(PD, 0, 0, 0, 0, 1'b0);
      chk("rst_mid.busy",  32'(busy),      32'd0);
      chk("rst_mid.ready", 32'(upd_ready), 32'd1);
      chk("rst_mid.idx7_hit", 32'(lk_hit), 32'd0);
      chk("rst_mid.idx7_tgt", lk_target,   32'd0);
      drive(PA, 0, 0, 0, 0, 1'b0);
      chk("rst_mid.idx2_hit", 32'(lk_hit), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ysyx_24100029_btb_ctrl
